dual_port_ram_arbiter: RTL and testbench

Round-robin arbiter that shares the two ports of `Dual_Port_RAM` among three requesters (A, B, C). Each cycle it grants up to two requests, maps them onto RAM port 1 and port 2, and resolves same-address conflicts. It returns read data to the requester with a one-cycle valid strobe. It sits between the requester logic and a single `Dual_Port_RAM` instance.

---
 rtl/dual_port_ram_arbiter.sv | 151 +++++++++++++++
 tb/tb_dual_port_ram_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_port_ram_arbiter.sv
// Round-robin arbiter sharing both ports of one dual-port RAM among requesters A, B and C.
// Up to two conflict-free accesses are granted per cycle; read data returns one cycle later.
module dual_port_ram_arbiter #(
  parameter int IN_DATA_WIDTH = 8,
  parameter int ADDR_WIDTH    = 6
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     Req_A,
  input  logic                     WE_A,
  input  logic [ADDR_WIDTH-1:0]    Address_A,
  input  logic [IN_DATA_WIDTH-1:0] Data_A,
  input  logic                     Req_B,
  input  logic                     WE_B,
  input  logic [ADDR_WIDTH-1:0]    Address_B,
  input  logic [IN_DATA_WIDTH-1:0] Data_B,
  input  logic                     Req_C,
  input  logic                     WE_C,
  input  logic [ADDR_WIDTH-1:0]    Address_C,
  input  logic [IN_DATA_WIDTH-1:0] Data_C,
  output logic                     Gnt_A,
  output logic                     Gnt_B,
  output logic                     Gnt_C,
  output logic                     Rd_Valid_A,
  output logic                     Rd_Valid_B,
  output logic                     Rd_Valid_C,
  output logic [IN_DATA_WIDTH-1:0] Rd_Data_A,
  output logic [IN_DATA_WIDTH-1:0] Rd_Data_B,
  output logic [IN_DATA_WIDTH-1:0] Rd_Data_C,
  output logic [ADDR_WIDTH-1:0]    Address_1,
  output logic [ADDR_WIDTH-1:0]    Address_2,
  output logic [IN_DATA_WIDTH-1:0] Data_1,
  output logic [IN_DATA_WIDTH-1:0] Data_2,
  output logic                     WE_1,
  output logic                     WE_2,
  input  logic [IN_DATA_WIDTH-1:0] Output_1,
  input  logic [IN_DATA_WIDTH-1:0] Output_2
);

  logic [2:0]               req;
  logic [2:0]               we;
  logic [ADDR_WIDTH-1:0]    addr [3];
  logic [IN_DATA_WIDTH-1:0] wdata [3];
  logic [1:0]               ord [3];
  logic [1:0]               search_idx;
  logic [2:0]               gnt;
  logic [2:0]               port2_sel;
  logic                     first_found;
  logic                     second_found;
  logic [1:0]               first_idx;
  logic [1:0]               second_idx;
  logic [1:0]               ptr_q, ptr_d;
  logic [2:0]               rd_valid_q, rd_valid_d;
  logic [2:0]               rd_port_q, rd_port_d;

  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  assign req      = {Req_C, Req_B, Req_A};
  assign we       = {WE_C, WE_B, WE_A};
  assign addr[0]  = Address_A;
  assign addr[1]  = Address_B;
  assign addr[2]  = Address_C;
  assign wdata[0] = Data_A;
  assign wdata[1] = Data_B;
  assign wdata[2] = Data_C;

  always_comb begin
    ord[0] = ptr_q;
    ord[1] = next_idx(ptr_q);
    ord[2] = next_idx(next_idx(ptr_q));
  end

  // Later candidates are only ever checked against the port-1 winner, so a conflicting
  // second candidate simply yields its slot to the third one.
  always_comb begin
    gnt          = '0;
    port2_sel    = '0;
    first_found  = 1'b0;
    second_found = 1'b0;
    first_idx    = '0;
    second_idx   = '0;
    search_idx   = '0;
    for (int i = 0; i < 3; i++) begin
      search_idx = ord[i];
      if (RST && req[search_idx]) begin
        if (!first_found) begin
          first_found       = 1'b1;
          first_idx         = search_idx;
          gnt[search_idx]   = 1'b1;
        end else if (!second_found &&
                     !((addr[search_idx] == addr[first_idx]) &&
                       (we[search_idx] || we[first_idx]))) begin
          second_found          = 1'b1;
          second_idx            = search_idx;
          gnt[search_idx]       = 1'b1;
          port2_sel[search_idx] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    WE_1      = first_found & we[first_idx];
    Address_1 = first_found ? addr[first_idx] : '0;
    Data_1    = first_found ? wdata[first_idx] : '0;
    WE_2      = second_found & we[second_idx];
    Address_2 = second_found ? addr[second_idx] : '0;
    Data_2    = second_found ? wdata[second_idx] : '0;
  end

  assign Gnt_A = gnt[0];
  assign Gnt_B = gnt[1];
  assign Gnt_C = gnt[2];

  always_comb begin
    rd_valid_d = gnt & ~we;
    rd_port_d  = port2_sel & ~we;
    if (second_found) begin
      ptr_d = next_idx(second_idx);
    end else if (first_found) begin
      ptr_d = next_idx(first_idx);
    end else begin
      ptr_d = ptr_q;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ptr_q      <= '0;
      rd_valid_q <= '0;
      rd_port_q  <= '0;
    end else begin
      ptr_q      <= ptr_d;
      rd_valid_q <= rd_valid_d;
      rd_port_q  <= rd_port_d;
    end
  end

  // Read data is steered by the port each read used and forced to zero when not valid.
  always_comb begin
    Rd_Valid_A = rd_valid_q[0];
    Rd_Valid_B = rd_valid_q[1];
    Rd_Valid_C = rd_valid_q[2];
    Rd_Data_A  = rd_valid_q[0] ? (rd_port_q[0] ? Output_2 : Output_1) : '0;
    Rd_Data_B  = rd_valid_q[1] ? (rd_port_q[1] ? Output_2 : Output_1) : '0;
    Rd_Data_C  = rd_valid_q[2] ? (rd_port_q[2] ? Output_2 : Output_1) : '0;
  end

endmodule

// File: tb/tb_dual_port_ram_arbiter.sv
// Self-checking bench for dual_port_ram_arbiter with a behavioural dual-port RAM attached.
// Directed scenarios use hand-derived constants; the random phase uses a queue-based model.
module tb_dual_port_ram_arbiter;
  localparam int DW = 8;
  localparam int AW = 6;

  logic          CLK = 1'b0;
  logic          RST;
  logic          req [3];
  logic          we [3];
  logic [AW-1:0] addr [3];
  logic [DW-1:0] data [3];

  logic          Gnt_A, Gnt_B, Gnt_C;
  logic          Rd_Valid_A, Rd_Valid_B, Rd_Valid_C;
  logic [DW-1:0] Rd_Data_A, Rd_Data_B, Rd_Data_C;
  logic [AW-1:0] Address_1, Address_2;
  logic [DW-1:0] Data_1, Data_2;
  logic          WE_1, WE_2;
  logic [DW-1:0] Output_1, Output_2;

  logic [2:0]    gnt_v;
  logic [2:0]    rdv_v;
  logic [DW-1:0] rdd [3];

  logic [DW-1:0] ram [64];
  logic [DW-1:0] model_mem [64];
  int            m_ptr;
  int            checks = 0;
  int            errors = 0;

  assign gnt_v  = {Gnt_C, Gnt_B, Gnt_A};
  assign rdv_v  = {Rd_Valid_C, Rd_Valid_B, Rd_Valid_A};
  assign rdd[0] = Rd_Data_A;
  assign rdd[1] = Rd_Data_B;
  assign rdd[2] = Rd_Data_C;

  always #5 CLK = ~CLK;

  dual_port_ram_arbiter #(.IN_DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .CLK(CLK), .RST(RST),
    .Req_A(req[0]), .WE_A(we[0]), .Address_A(addr[0]), .Data_A(data[0]),
    .Req_B(req[1]), .WE_B(we[1]), .Address_B(addr[1]), .Data_B(data[1]),
    .Req_C(req[2]), .WE_C(we[2]), .Address_C(addr[2]), .Data_C(data[2]),
    .Gnt_A(Gnt_A), .Gnt_B(Gnt_B), .Gnt_C(Gnt_C),
    .Rd_Valid_A(Rd_Valid_A), .Rd_Valid_B(Rd_Valid_B), .Rd_Valid_C(Rd_Valid_C),
    .Rd_Data_A(Rd_Data_A), .Rd_Data_B(Rd_Data_B), .Rd_Data_C(Rd_Data_C),
    .Address_1(Address_1), .Address_2(Address_2),
    .Data_1(Data_1), .Data_2(Data_2), .WE_1(WE_1), .WE_2(WE_2),
    .Output_1(Output_1), .Output_2(Output_2)
  );

  function automatic logic [DW-1:0] preload_val(input int a);
    case (a)
      1:       return 8'hD4;
      2:       return 8'hA3;
      3:       return 8'h5C;
      default: return (a >= 32) ? 8'((a * 37) ^ 8'h5A) : 8'h00;
    endcase
  endfunction

  // RAM stand-in: synchronous write and registered read on both ports.
  initial begin
    for (int a = 0; a < 64; a++) ram[a] = preload_val(a);
    forever begin
      @(posedge CLK);
      if (WE_1) ram[Address_1] <= Data_1;
      if (WE_2) ram[Address_2] <= Data_2;
      Output_1 <= ram[Address_1];
      Output_2 <= ram[Address_2];
    end
  end

  task automatic set_req(input int k, input logic r, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[k] = r; we[k] = w; addr[k] = a; data[k] = d;
  endtask

  task automatic idle_all();
    for (int k = 0; k < 3; k++) set_req(k, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic next_cycle();
    @(posedge CLK); #1;
  endtask

  task automatic to_mid();
    #4;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    set_req(0, 1'b1, 1'b0, 6'h01, 8'h00);
    set_req(1, 1'b1, 1'b0, 6'h02, 8'h00);
    set_req(2, 1'b1, 1'b0, 6'h03, 8'h00);
    next_cycle(); to_mid();
    checks++; if (gnt_v !== 3'b000) begin errors++; $display("[TB] FAIL rst_gnt got %b want 000", gnt_v); end
    checks++; if ({WE_1, WE_2} !== 2'b00) begin errors++; $display("[TB] FAIL rst_we got %b want 00", {WE_1, WE_2}); end
    checks++; if ({Address_1, Data_1, Address_2, Data_2} !== '0) begin errors++; $display("[TB] FAIL rst_ports got %h %h %h %h want 0", Address_1, Data_1, Address_2, Data_2); end
    checks++; if (rdv_v !== 3'b000) begin errors++; $display("[TB] FAIL rst_rdv got %b want 000", rdv_v); end
    next_cycle();
    RST = 1'b1;
    to_mid();
    checks++; if (gnt_v !== 3'b011) begin errors++; $display("[TB] FAIL rel_gnt got %b want 011", gnt_v); end
    checks++; if ({Address_1, Address_2} !== {6'h01, 6'h02}) begin errors++; $display("[TB] FAIL rel_ports got %h %h want 01 02", Address_1, Address_2); end
    next_cycle();
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    to_mid();
    checks++; if (gnt_v !== 3'b100) begin errors++; $display("[TB] FAIL rel_c_gnt got %b want 100", gnt_v); end
    checks++; if (rdv_v !== 3'b011) begin errors++; $display("[TB] FAIL rel_rdv got %b want 011", rdv_v); end
    checks++; if ({rdd[0], rdd[1]} !== {8'hD4, 8'hA3}) begin errors++; $display("[TB] FAIL rel_rdd got %h %h want d4 a3", rdd[0], rdd[1]); end
    next_cycle();
    idle_all();
    to_mid();
    checks++; if (rdv_v !== 3'b100 || rdd[2] !== 8'h5C) begin errors++; $display("[TB] FAIL rel_c_rd got %b %h want 100 5c", rdv_v, rdd[2]); end
    next_cycle();
  endtask

  task automatic test_fairness();
    logic [2:0]    pat [3];
    logic [DW-1:0] expv [3];
    logic [2:0]    prev;
    pat  = '{3'b011, 3'b101, 3'b110};
    expv = '{8'hD4, 8'hA3, 8'h5C};
    prev = 3'b000;
    set_req(0, 1'b1, 1'b0, 6'h01, 8'h00);
    set_req(1, 1'b1, 1'b0, 6'h02, 8'h00);
    set_req(2, 1'b1, 1'b0, 6'h03, 8'h00);
    for (int c = 0; c < 7; c++) begin
      if (c == 6) idle_all();
      to_mid();
      if (c < 6) begin
        checks++; if (gnt_v !== pat[c % 3]) begin errors++; $display("[TB] FAIL fair_gnt cyc %0d got %b want %b", c, gnt_v, pat[c % 3]); end
      end
      checks++; if (rdv_v !== prev) begin errors++; $display("[TB] FAIL fair_rdv cyc %0d got %b want %b", c, rdv_v, prev); end
      for (int k = 0; k < 3; k++) begin
        if (prev[k]) begin
          checks++; if (rdd[k] !== expv[k]) begin errors++; $display("[TB] FAIL fair_rdd cyc %0d req %0d got %h want %h", c, k, rdd[k], expv[k]); end
        end
      end
      prev = (c < 6) ? pat[c % 3] : 3'b000;
      next_cycle();
    end
  endtask

  task automatic test_write_read();
    set_req(0, 1'b1, 1'b1, 6'h00, 8'hB5);
    to_mid();
    checks++; if (gnt_v !== 3'b001) begin errors++; $display("[TB] FAIL wr_gnt got %b want 001", gnt_v); end
    checks++; if ({WE_1, Address_1, Data_1} !== {1'b1, 6'h00, 8'hB5}) begin errors++; $display("[TB] FAIL wr_port1 got %b %h %h want 1 00 b5", WE_1, Address_1, Data_1); end
    checks++; if ({WE_2, Address_2, Data_2} !== '0) begin errors++; $display("[TB] FAIL wr_port2_idle got %b %h %h want 0 00 00", WE_2, Address_2, Data_2); end
    next_cycle();
    set_req(0, 1'b1, 1'b0, 6'h00, 8'h00);
    to_mid();
    checks++; if (gnt_v !== 3'b001 || WE_1 !== 1'b0) begin errors++; $display("[TB] FAIL rd_gnt got %b we %b want 001 we 0", gnt_v, WE_1); end
    checks++; if (rdv_v !== 3'b000) begin errors++; $display("[TB] FAIL wr_no_rdv got %b want 000", rdv_v); end
    next_cycle();
    idle_all();
    to_mid();
    checks++; if (rdv_v !== 3'b001 || rdd[0] !== 8'hB5) begin errors++; $display("[TB] FAIL rd_data got %b %h want 001 b5", rdv_v, rdd[0]); end
    next_cycle();
  endtask

  task automatic test_rw_conflict();
    set_req(1, 1'b1, 1'b1, 6'h06, 8'h77);
    set_req(2, 1'b1, 1'b0, 6'h06, 8'h00);
    to_mid();
    checks++; if (gnt_v !== 3'b010) begin errors++; $display("[TB] FAIL rw_gnt got %b want 010", gnt_v); end
    checks++; if ({WE_1, Address_1, Data_1, WE_2} !== {1'b1, 6'h06, 8'h77, 1'b0}) begin errors++; $display("[TB] FAIL rw_ports got %b %h %h %b", WE_1, Address_1, Data_1, WE_2); end
    next_cycle();
    set_req(1, 1'b0, 1'b0, '0, '0);
    to_mid();
    checks++; if (gnt_v !== 3'b100 || Address_1 !== 6'h06 || WE_1 !== 1'b0) begin errors++; $display("[TB] FAIL rw_c_gnt got %b %h %b", gnt_v, Address_1, WE_1); end
    checks++; if (rdv_v !== 3'b000) begin errors++; $display("[TB] FAIL rw_no_rdv got %b want 000", rdv_v); end
    next_cycle();
    idle_all();
    to_mid();
    checks++; if (rdv_v !== 3'b100 || rdd[2] !== 8'h77) begin errors++; $display("[TB] FAIL rw_rdd got %b %h want 100 77", rdv_v, rdd[2]); end
    next_cycle();
  endtask

  task automatic test_ww_conflict();
    set_req(0, 1'b1, 1'b1, 6'h04, 8'h11);
    set_req(1, 1'b1, 1'b1, 6'h04, 8'h22);
    set_req(2, 1'b1, 1'b0, 6'h05, 8'h00);
    to_mid();
    checks++; if (gnt_v !== 3'b101) begin errors++; $display("[TB] FAIL ww_gnt got %b want 101", gnt_v); end
    checks++; if ({WE_1, Address_1, Data_1} !== {1'b1, 6'h04, 8'h11}) begin errors++; $display("[TB] FAIL ww_port1 got %b %h %h", WE_1, Address_1, Data_1); end
    checks++; if ({WE_2, Address_2} !== {1'b0, 6'h05}) begin errors++; $display("[TB] FAIL ww_port2 got %b %h want 0 05", WE_2, Address_2); end
    next_cycle();
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(2, 1'b0, 1'b0, '0, '0);
    to_mid();
    checks++; if (gnt_v !== 3'b010 || {WE_1, Address_1, Data_1} !== {1'b1, 6'h04, 8'h22}) begin errors++; $display("[TB] FAIL ww_b_gnt got %b %b %h %h", gnt_v, WE_1, Address_1, Data_1); end
    checks++; if (rdv_v !== 3'b100 || rdd[2] !== 8'h00) begin errors++; $display("[TB] FAIL ww_c_rd got %b %h want 100 00", rdv_v, rdd[2]); end
    next_cycle();
    set_req(1, 1'b0, 1'b0, '0, '0);
    set_req(0, 1'b1, 1'b0, 6'h04, 8'h00);
    to_mid();
    checks++; if (gnt_v !== 3'b001) begin errors++; $display("[TB] FAIL ww_chk_gnt got %b want 001", gnt_v); end
    next_cycle();
    idle_all();
    to_mid();
    checks++; if (rdv_v !== 3'b001 || rdd[0] !== 8'h22) begin errors++; $display("[TB] FAIL ww_final got %b %h want 001 22", rdv_v, rdd[0]); end
    next_cycle();
  endtask

  task automatic test_reset_during_read();
    set_req(0, 1'b1, 1'b0, 6'h01, 8'h00);
    set_req(2, 1'b1, 1'b0, 6'h03, 8'h00);
    to_mid();
    checks++; if (gnt_v !== 3'b101 || {Address_1, Address_2} !== {6'h03, 6'h01}) begin errors++; $display("[TB] FAIL rdr_gnt got %b %h %h want 101 03 01", gnt_v, Address_1, Address_2); end
    next_cycle();
    set_req(1, 1'b1, 1'b0, 6'h02, 8'h00);
    checks++; if (rdv_v !== 3'b101 || rdd[2] !== 8'h5C) begin errors++; $display("[TB] FAIL rdr_pre got %b %h want 101 5c", rdv_v, rdd[2]); end
    RST = 1'b0;
    #1;
    checks++; if (rdv_v !== 3'b000 || rdd[2] !== 8'h00 || gnt_v !== 3'b000) begin errors++; $display("[TB] FAIL rdr_async got %b %h %b want 000 00 000", rdv_v, rdd[2], gnt_v); end
    next_cycle();
    next_cycle();
    RST = 1'b1;
    to_mid();
    checks++; if (gnt_v !== 3'b011) begin errors++; $display("[TB] FAIL rdr_ptr got %b want 011", gnt_v); end
    checks++; if (rdv_v !== 3'b000) begin errors++; $display("[TB] FAIL rdr_rel_rdv got %b want 000", rdv_v); end
    next_cycle();
    idle_all();
    to_mid();
    checks++; if (rdv_v !== 3'b011 || {rdd[0], rdd[1]} !== {8'hD4, 8'hA3}) begin errors++; $display("[TB] FAIL rdr_after got %b %h %h want 011 d4 a3", rdv_v, rdd[0], rdd[1]); end
    next_cycle();
    to_mid();
    checks++; if (rdv_v !== 3'b000) begin errors++; $display("[TB] FAIL rdr_quiet got %b want 000", rdv_v); end
    next_cycle();
  endtask

  // Reference arbitration: rotate the requesters from the model pointer, take the first,
  // then the first remaining one that does not clash with it.
  task automatic model_grant(output int p1, output int p2);
    int cand [$];
    p1 = -1;
    p2 = -1;
    for (int i = 0; i < 3; i++) if (req[(m_ptr + i) % 3]) cand.push_back((m_ptr + i) % 3);
    if (cand.size() > 0) p1 = cand.pop_front();
    while (p2 < 0 && cand.size() > 0) begin
      int c;
      c = cand.pop_front();
      if (!(addr[c] == addr[p1] && (we[c] || we[p1]))) p2 = c;
    end
  endtask

  task automatic test_random();
    int            p1, p2, last;
    bit            pending [3];
    logic [2:0]    exp_g, exp_rdv, nrdv;
    logic [DW-1:0] exp_rdd [3];
    logic [DW-1:0] nrdd [3];
    logic [14:0]   exp_p1, exp_p2;
    RST = 1'b0;
    idle_all();
    next_cycle();
    RST = 1'b1;
    m_ptr   = 0;
    exp_rdv = '0;
    for (int k = 0; k < 3; k++) begin exp_rdd[k] = '0; pending[k] = 1'b0; end
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 3; k++) begin
        if (!pending[k]) begin
          if ($urandom_range(0, 9) < 6) begin
            pending[k] = 1'b1;
            set_req(k, 1'b1, 1'($urandom_range(0, 1)), 6'(32 + $urandom_range(0, 3)), 8'($urandom));
          end else begin
            set_req(k, 1'b0, 1'($urandom_range(0, 1)), 6'($urandom), 8'($urandom));
          end
        end
      end
      model_grant(p1, p2);
      exp_g  = '0;
      exp_p1 = '0;
      exp_p2 = '0;
      if (p1 >= 0) begin exp_g[p1] = 1'b1; exp_p1 = {we[p1], addr[p1], data[p1]}; end
      if (p2 >= 0) begin exp_g[p2] = 1'b1; exp_p2 = {we[p2], addr[p2], data[p2]}; end
      to_mid();
      checks++; if (gnt_v !== exp_g) begin errors++; $display("[TB] FAIL rnd_gnt cyc %0d got %b want %b", c, gnt_v, exp_g); end
      checks++; if ({WE_1, Address_1, Data_1} !== exp_p1) begin errors++; $display("[TB] FAIL rnd_port1 cyc %0d got %h want %h", c, {WE_1, Address_1, Data_1}, exp_p1); end
      checks++; if ({WE_2, Address_2, Data_2} !== exp_p2) begin errors++; $display("[TB] FAIL rnd_port2 cyc %0d got %h want %h", c, {WE_2, Address_2, Data_2}, exp_p2); end
      checks++; if (rdv_v !== exp_rdv) begin errors++; $display("[TB] FAIL rnd_rdv cyc %0d got %b want %b", c, rdv_v, exp_rdv); end
      for (int k = 0; k < 3; k++) begin
        checks++; if (rdd[k] !== exp_rdd[k]) begin errors++; $display("[TB] FAIL rnd_rdd cyc %0d req %0d got %h want %h", c, k, rdd[k], exp_rdd[k]); end
      end
      for (int k = 0; k < 3; k++) begin
        nrdv[k] = exp_g[k] && !we[k];
        nrdd[k] = nrdv[k] ? model_mem[addr[k]] : 8'h00;
      end
      for (int k = 0; k < 3; k++) begin
        if (exp_g[k] && we[k]) model_mem[addr[k]] = data[k];
        if (exp_g[k]) pending[k] = 1'b0;
      end
      exp_rdv = nrdv;
      for (int k = 0; k < 3; k++) exp_rdd[k] = nrdd[k];
      last = (p2 >= 0) ? p2 : p1;
      if (last >= 0) m_ptr = (last + 1) % 3;
      next_cycle();
    end
    idle_all();
  endtask

  initial begin
    for (int a = 0; a < 64; a++) model_mem[a] = preload_val(a);
    m_ptr = 0;
    RST   = 1'b0;
    idle_all();
    #1;
    test_reset();
    test_fairness();
    test_write_read();
    test_rw_conflict();
    test_ww_conflict();
    test_reset_during_read();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
